// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared coin encoding, classifier states and coin decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package coin_pkg;

    localparam int c_coin_w = 2;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_NICKLE  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } cls_state_e;

    // Returns {quarter, dime, nickle}; COIN_NONE decodes to no pulse.
    function automatic logic [2:0] coin_to_onehot(input coin_e coin);
        logic [2:0] oh;
        case (coin)
            COIN_NICKLE:  oh = 3'b001;
            COIN_DIME:    oh = 3'b010;
            COIN_QUARTER: oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_fifo.sv
`default_nettype none
// ============================================================================
// Module      : coin_fifo
// Description : Synchronous FIFO with wrap-bit pointers; power-of-two DEPTH.
// Revision    : 1.0  initial release
// ============================================================================
module coin_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= din;
                r_wr_ptr                  <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Synchronises, debounces and classifies raw coin sensors, buffers
//               accepted coins and emits one-cycle one-hot coin pulses.
// Revision    : 1.0  initial release
// ============================================================================
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               raw_nickle,
    input  logic               raw_dime,
    input  logic               raw_quarter,
    input  logic               accept_en,
    output logic               nickle,
    output logic               dime,
    output logic               quarter,
    output logic               reject,
    output logic               fifo_full,
    output logic [COUNT_W-1:0] coin_count
);

    localparam int c_dbw = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_dbw-1:0] c_db_last = c_dbw'(DEBOUNCE_CYCLES - 1);

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [2:0] w_raw;
    logic [2:0] w_synced;
    logic [2:0] w_filt;

    assign w_raw = {raw_quarter, raw_dime, raw_nickle};

    for (genvar i = 0; i < 3; i++) begin : g_line
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_dbw-1:0]       r_cnt;
        logic                   r_filt;

        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
            end
        end

        assign w_synced[i] = r_sync[SYNC_STAGES-1];

        // Filtered level only follows after DEBOUNCE_CYCLES consecutive disagreements.
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else if (w_synced[i] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_db_last) begin
                r_filt <= w_synced[i];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_dbw'(1);
            end
        end

        assign w_filt[i] = r_filt;
    end

    cls_state_e r_state;
    cls_state_e w_state_nxt;
    coin_e      w_coin;
    logic       w_push;
    logic       w_reject;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [c_coin_w-1:0] w_fifo_dout;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_coin      = COIN_NONE;
        w_push      = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_filt) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                case (w_filt)
                    3'b000:  w_coin = COIN_NONE;
                    3'b001:  w_coin = COIN_NICKLE;
                    3'b010:  w_coin = COIN_DIME;
                    3'b100:  w_coin = COIN_QUARTER;
                    default: w_reject = 1'b1;
                endcase
                if (w_filt == 3'b000) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                    if (w_coin != COIN_NONE) begin
                        if (w_fifo_full) begin
                            w_reject = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_filt == 3'b000) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic [2:0]         r_onehot;
    logic               r_reject;
    logic [COUNT_W-1:0] r_count;
    logic               w_pop;

    // A pulse this cycle blocks the pop, forcing an idle cycle between coins.
    assign w_pop = accept_en && !w_fifo_empty && (r_onehot == 3'b000);

    coin_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_coin_w)
    ) u_fifo (
        .clk   (clk),
        .rst_n (w_rst_n),
        .push  (w_push),
        .din   (w_coin),
        .pop   (w_pop),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .dout  (w_fifo_dout)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_onehot <= 3'b000;
            r_reject <= 1'b0;
            r_count  <= '0;
        end else begin
            r_reject <= w_reject;
            r_onehot <= w_pop ? coin_to_onehot(coin_e'(w_fifo_dout)) : 3'b000;
            if (w_pop && (r_count != {COUNT_W{1'b1}})) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign {quarter, dime, nickle} = r_onehot;
    assign reject                  = r_reject;
    assign fifo_full               = w_fifo_full;
    assign coin_count              = r_count;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Self-checking bench: vector table, scoreboard queue and corner sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_coin_acceptor;

    logic       clk;
    logic       rst_n;
    logic       raw_nickle;
    logic       raw_dime;
    logic       raw_quarter;
    logic       accept_en;
    logic       nickle;
    logic       dime;
    logic       quarter;
    logic       reject;
    logic       fifo_full;
    logic [7:0] coin_count;

    coin_acceptor #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .COUNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_nickle  (raw_nickle),
        .raw_dime    (raw_dime),
        .raw_quarter (raw_quarter),
        .accept_en   (accept_en),
        .nickle      (nickle),
        .dime        (dime),
        .quarter     (quarter),
        .reject      (reject),
        .fifo_full   (fifo_full),
        .coin_count  (coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raw;      // {q,d,n}
        int         hold;
        logic [2:0] exp_oh;   // expected pulse {q,d,n}, 0 = none
        int         exp_rej;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] exp_q[$];
    int         exp_count = 0;
    int         rej_seen  = 0;
    int         pulse_seen = 0;
    logic       prev_pulse = 1'b0;
    logic [2:0] mon_oh;
    logic [2:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every coin pulse is matched against the next expected coin.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_oh = {quarter, dime, nickle};
            if (reject) rej_seen++;
            if (mon_oh != 3'b000) begin
                pulse_seen++;
                check("pulse_onehot", 32'($countones(mon_oh)), 32'd1);
                check("pulse_gap", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, mon_oh}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pulse_coin", {29'd0, mon_oh}, {29'd0, mon_exp});
                end
            end
            prev_pulse = (mon_oh != 3'b000);
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic insert(input logic [2:0] raw, input int hold, input int settle);
        {raw_quarter, raw_dime, raw_nickle} = raw;
        repeat (hold) @(negedge clk);
        {raw_quarter, raw_dime, raw_nickle} = 3'b000;
        repeat (settle) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int r0;
        r0 = rej_seen;
        if (v.exp_oh != 3'b000) begin
            exp_q.push_back(v.exp_oh);
            exp_count++;
        end
        insert(v.raw, v.hold, 30);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_rejects"}, 32'(rej_seen - r0), 32'(v.exp_rej));
        check({name, "_count"}, {24'd0, coin_count}, 32'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   r0;
        int   p0;
        int   lat;
        logic after_lat;
        int   n;
        int   t[4];

        vecs[0] = '{raw: 3'b001, hold: 6, exp_oh: 3'b001, exp_rej: 0};
        vecs[1] = '{raw: 3'b100, hold: 6, exp_oh: 3'b100, exp_rej: 0};
        vecs[2] = '{raw: 3'b100, hold: 2, exp_oh: 3'b000, exp_rej: 0};
        vecs[3] = '{raw: 3'b011, hold: 8, exp_oh: 3'b000, exp_rej: 1};
        vecs[4] = '{raw: 3'b110, hold: 8, exp_oh: 3'b000, exp_rej: 1};
        vecs[5] = '{raw: 3'b111, hold: 5, exp_oh: 3'b000, exp_rej: 1};
        vecs[6] = '{raw: 3'b001, hold: 3, exp_oh: 3'b000, exp_rej: 0};
        vecs[7] = '{raw: 3'b010, hold: 4, exp_oh: 3'b010, exp_rej: 0};
        vecs[8] = '{raw: 3'b001, hold: 1, exp_oh: 3'b000, exp_rej: 0};

        rst_n = 1'b0;
        {raw_quarter, raw_dime, raw_nickle} = 3'b000;
        accept_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pulses", {28'd0, quarter, dime, nickle, reject}, 32'd0);
        check("reset_full", {31'd0, fifo_full}, 32'd0);
        check("reset_count", {24'd0, coin_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single dime: latency from first sampling edge and single-cycle width.
        r0 = rej_seen;
        exp_q.push_back(3'b010);
        exp_count++;
        raw_dime = 1'b1;
        lat = 0;
        after_lat = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 10) raw_dime = 1'b0;
            if (lat != 0 && k == lat + 1) after_lat = dime;
            if (dime && lat == 0) lat = k;
        end
        check("dime_latency", 32'(lat), 32'd9);
        check("dime_width", {31'd0, after_lat}, 32'd0);
        repeat (20) @(negedge clk);
        check("dime_count", {24'd0, coin_count}, 32'd1);
        check("dime_rejects", 32'(rej_seen - r0), 32'd0);
        check("dime_drained", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall and overflow: four buffered, fifth returned.
        accept_en = 1'b0;
        p0 = pulse_seen;
        r0 = rej_seen;
        for (int i = 0; i < 4; i++) insert(3'b001, 6, 16);
        check("stall_full", {31'd0, fifo_full}, 32'd1);
        insert(3'b001, 6, 16);
        check("overflow_reject", 32'(rej_seen - r0), 32'd1);
        check("stall_no_pulse", 32'(pulse_seen - p0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(3'b001);
            exp_count++;
        end
        accept_en = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (nickle) begin
                if (n == 0) check("full_drops", {31'd0, fifo_full}, 32'd0);
                if (n < 4) t[n] = k;
                n++;
            end
        end
        check("drain_pulses", 32'(n), 32'd4);
        check("drain_first", 32'(t[0]), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check("drain_spacing", 32'(t[i] - t[i-1]), 32'd2);
        end
        check("drain_count", {24'd0, coin_count}, 32'(exp_count));

        // Simultaneous push and pop with three coins buffered.
        accept_en = 1'b0;
        r0 = rej_seen;
        insert(3'b001, 6, 16);
        insert(3'b010, 6, 16);
        insert(3'b001, 6, 16);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b100);
        exp_count += 4;
        for (int k = 1; k <= 8; k++) begin
            raw_quarter = (k <= 6);
            accept_en   = (k >= 8);
            @(negedge clk);
        end
        check("simul_pop", {31'd0, nickle}, 32'd1);
        check("simul_not_full", {31'd0, fifo_full}, 32'd0);
        repeat (30) @(negedge clk);
        check("simul_drained", 32'(exp_q.size()), 32'd0);
        check("simul_rejects", 32'(rej_seen - r0), 32'd0);
        check("simul_count", {24'd0, coin_count}, 32'(exp_count));

        // Reset mid-operation discards buffered coins.
        accept_en = 1'b0;
        for (int i = 0; i < 3; i++) insert(3'b100, 6, 16);
        rst_n = 1'b0;
        #1;
        check("midrst_pulses", {28'd0, quarter, dime, nickle, reject}, 32'd0);
        check("midrst_full", {31'd0, fifo_full}, 32'd0);
        check("midrst_count", {24'd0, coin_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        p0 = pulse_seen;
        accept_en = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_pulse", 32'(pulse_seen - p0), 32'd0);
        check("midrst_count_after", {24'd0, coin_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
